// File: rtl/seq_sub_signed_pkg.sv
// Shared types for the digit-serial signed subtractor.
package seq_sub_signed_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_sub_signed_if.sv
// Request/result bundle between a client and seq_sub_signed.
interface seq_sub_signed_if #(
    parameter int unsigned N = 8,
    parameter int unsigned M = N
);
    logic         start;
    logic [N-1:0] A;
    logic [M-1:0] B;
    logic         busy;
    logic         done;
    logic [N:0]   O;

    modport master (output start, A, B, input busy, done, O);
    modport slave  (input start, A, B, output busy, done, O);
endinterface

// File: rtl/seq_sub_digit.sv
// One W-bit ripple slice computing a + ~b + ci.
module seq_sub_digit #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W:0]   c;
    logic [W-1:0] nb;

    always_comb begin
        nb   = ~b;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = a[i] ^ nb[i] ^ c[i];
            c[i+1] = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
        end
        co    = c[W];
        c_msb = c[W-1];
    end
endmodule

// File: rtl/seq_sub_signed.sv
// Digit-serial signed subtractor: O = A - B, W bits per clock, N+1-bit result.
module seq_sub_signed
    import seq_sub_signed_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned M = N,
    parameter int unsigned W = 1
) (
    input  logic             clk,
    input  logic             rst,
    seq_sub_signed_if.slave  bus
);
    localparam int unsigned DIGITS = N / W;
    localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic             carry_q;
    logic [N:0]       o_q;
    logic             busy_q;
    logic             done_q;

    logic [N-1:0]     b_ext;
    logic [W-1:0]     sum;
    logic             co;
    logic             c_msb;
    logic             last_digit;
    logic             sign;

    assign b_ext      = N'($signed(bus.B));
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));
    // Result sign = N-bit sign corrected by overflow (carry into vs out of bit N-1).
    assign sign       = sum[W-1] ^ c_msb ^ co;

    seq_sub_digit #(.W(W)) u_digit (
        .a     (a_q[W-1:0]),
        .b     (b_q[W-1:0]),
        .ci    (carry_q),
        .s     (sum),
        .co    (co),
        .c_msb (c_msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    for (int unsigned j = 0; j < DIGITS; j++) begin
                        if (cnt_q == CNT_W'(j)) o_q[j*W +: W] <= sum;
                    end
                    carry_q <= co;
                    a_q     <= a_q >> W;
                    b_q     <= b_q >> W;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_digit) begin
                        o_q[N]  <= sign;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q        <= bus.A;
                        b_q        <= b_ext;
                        carry_q    <= 1'b1;
                        cnt_q      <= '0;
                        o_q[N-1:0] <= '0;
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.O    = o_q;
endmodule

// File: tb/tb_seq_sub_signed.sv
// Directed and randomised checks of seq_sub_signed in three width configurations.
module tb_seq_sub_signed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_sub_signed_if #(.N(8),  .M(8))  ifa ();
    seq_sub_signed_if #(.N(8),  .M(4))  ifb ();
    seq_sub_signed_if #(.N(16), .M(16)) ifc ();

    seq_sub_signed #(.N(8),  .M(8),  .W(1)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    seq_sub_signed #(.N(8),  .M(4),  .W(2)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    seq_sub_signed #(.N(16), .M(16), .W(4)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input int u, input logic s, input logic [15:0] a, input logic [15:0] b);
        case (u)
            0:       begin ifa.start = s; ifa.A = a[7:0]; ifa.B = b[7:0]; end
            1:       begin ifb.start = s; ifb.A = a[7:0]; ifb.B = b[3:0]; end
            default: begin ifc.start = s; ifc.A = a;      ifc.B = b;      end
        endcase
    endtask

    function automatic logic [16:0] o_of(input int u);
        case (u)
            0:       return 17'(ifa.O);
            1:       return 17'(ifb.O);
            default: return ifc.O;
        endcase
    endfunction

    function automatic logic done_of(input int u);
        case (u)
            0:       return ifa.done;
            1:       return ifb.done;
            default: return ifc.done;
        endcase
    endfunction

    function automatic logic busy_of(input int u);
        case (u)
            0:       return ifa.busy;
            1:       return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    function automatic int digits_of(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    // Wait (bounded) for done after an accepting edge; returns edges elapsed and busy count.
    task automatic wait_done(input int u, output logic seen, output int lat, output int busy_n);
        seen = 1'b0; lat = 0; busy_n = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (busy_of(u)) busy_n++;
            if (done_of(u)) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
    endtask

    task automatic op(input int u, input logic [15:0] a, input logic [15:0] b,
                      input logic [16:0] exp, input string tag);
        logic seen;
        int   lat, busy_n;
        @(negedge clk); drive(u, 1'b1, a, b);
        @(posedge clk); #1;
        drive(u, 1'b0, 16'($urandom), 16'($urandom));
        wait_done(u, seen, lat, busy_n);
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_lat"},  32'(lat), 32'(digits_of(u)));
        check({tag, "_busy"}, 32'(busy_n), 32'(digits_of(u)));
        check({tag, "_O"},    32'(o_of(u)), 32'(exp));
        @(posedge clk); #1;
        check({tag, "_pulse"},  32'(done_of(u)), 32'd0);
        check({tag, "_stable"}, 32'(o_of(u)), 32'(exp));
    endtask

    initial begin
        logic        seen;
        int          lat, busy_n;
        logic [15:0] ra, rb;
        logic [8:0]  d9;
        logic [16:0] d17;

        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_busy%0d", u), 32'(busy_of(u)), 32'd0);
            check($sformatf("rst_done%0d", u), 32'(done_of(u)), 32'd0);
            check($sformatf("rst_O%0d", u),    32'(o_of(u)), 32'd0);
        end
        @(negedge clk); rst = 1'b0;

        op(0, 16'h05, 16'h07, 17'h1FE, "a_5m7");
        op(0, 16'h80, 16'h01, 17'h17F, "a_m128m1");
        op(0, 16'h7F, 16'h80, 17'h0FF, "a_127pm128");
        op(0, 16'h00, 16'h00, 17'h000, "a_zero");
        op(1, 16'h10, 16'h0F, 17'h011, "b_16pm1");
        op(1, 16'h10, 16'h07, 17'h009, "b_16m7");
        op(1, 16'h80, 16'h07, 17'h179, "b_m128m7");
        op(2, 16'h8000, 16'h7FFF, 17'h10001, "c_minmax");
        op(2, 16'h7FFF, 16'h8000, 17'h0FFFF, "c_maxmin");
        op(2, 16'h1234, 16'h0234, 17'h01000, "c_mid");

        // Back-to-back: start held through RUN and DONE.
        @(negedge clk); drive(0, 1'b1, 16'h03, 16'h05);
        @(posedge clk); #1;
        drive(0, 1'b1, 16'h40, 16'hC0);
        wait_done(0, seen, lat, busy_n);
        check("b2b1_done", 32'(seen), 32'd1);
        check("b2b1_lat",  32'(lat), 32'd8);
        check("b2b1_O",    32'(o_of(0)), 32'h1FE);
        @(posedge clk); #1;
        check("b2b2_accept", 32'(busy_of(0)), 32'd1);
        drive(0, 1'b0, 16'h11, 16'h22);
        wait_done(0, seen, lat, busy_n);
        check("b2b2_done", 32'(seen), 32'd1);
        check("b2b2_lat",  32'(lat), 32'd8);
        check("b2b2_O",    32'(o_of(0)), 32'h080);
        @(posedge clk); #1;

        // Reset mid-RUN at digit 3.
        @(negedge clk); drive(0, 1'b1, 16'h55, 16'h2A);
        @(posedge clk); #1;
        drive(0, 1'b0, 16'h00, 16'h00);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(busy_of(0)), 32'd0);
        check("mid_rst_done", 32'(done_of(0)), 32'd0);
        check("mid_rst_O",    32'(o_of(0)), 32'd0);
        @(negedge clk); rst = 1'b0;
        op(0, 16'h55, 16'h2A, 17'h02B, "post_rst");

        for (int k = 0; k < 150; k++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            d9 = 9'($signed(ra[7:0])) - 9'($signed(rb[7:0]));
            op(0, ra, rb, 17'(d9), "rnd_a");
            d9 = 9'($signed(ra[7:0])) - 9'($signed(rb[3:0]));
            op(1, ra, rb, 17'(d9), "rnd_b");
            d17 = 17'($signed(ra)) - 17'($signed(rb));
            op(2, ra, rb, d17, "rnd_c");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
